mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control FSM that sequences the shared 32-bit ALU, register file, memory and PC for lw, sw, R-type, beq, bne, addi and j.
- Decodes op/funct from the instruction register and drives mux selects, write enables and the 3-bit alucontrol each cycle.
- The ALU alucontrol encoding is: bit2 inverts srcb and supplies carry-in; [1:0] selects 00 AND, 01 OR, 10 SUM, 11 SLT.
- Sits beside the multicycle datapath; the ALU zero flag feeds back to resolve branches.

Parameters:
SUPPORT_BNE, 1, when 1 opcode 000101 branches on !zero; when 0 it is illegal.

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
pcen  out  1  PC register enable
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
regwrite  out  1  register file write
iord  out  1  memory address select: 0 PC, 1 ALUOut
memtoreg  out  1  writeback select: 0 ALUOut, 1 data
regdst  out  1  dest select: 0 rt, 1 rd
alusrca  out  1  srca select: 0 PC, 1 A
alusrcb  out  2  srcb: 00 B, 01 const 4, 10 signimm, 11 signimm<<2
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
alucontrol  out  3  ALU function
illegal  out  1  one-cycle pulse in DECODE on an unsupported op/funct

Behaviour:
- State register is binary, 4 bits. reset_n low forces state FETCH asynchronously. While reset_n is low, pcen, memwrite, irwrite and regwrite are forced to 0; other outputs hold their FETCH values.
- All outputs are combinational from state, op, funct and zero (Moore plus the branch term). Default for every output is 0; alucontrol defaults to 010 (add).
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1. Next state DECODE.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100, or 000101 when SUPPORT_BNE=1 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - anything else -> FETCH with illegal=1
- MEMADR: alusrca=1, alusrcb=10, add. Next MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - Any other funct: illegal=1 already pulsed in DECODE, and DECODE sends state to FETCH instead.
  - Next RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1; bne=1 when op=000101. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- pcen = pcwrite | (branch & (zero ^ bne)).
- Unused state encodings go to FETCH with all write enables 0.
- Cycle counts:
  - lw 5
  - sw, R-type, addi 4
  - beq, bne, j 3
  - illegal 2
- Reset asserted mid-instruction: the in-flight write enable drops immediately; after release the first cycle is FETCH.
- op/funct are sampled only from the IR; the IR is stable outside FETCH because irwrite=1 only there.

Test Plan:
- Reset: reset_n=0 asserted mid-MEMWR -> memwrite drops to 0 in the same cycle; after release state=FETCH, irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op=100011): 5 cycles FETCH,DECODE,MEMADR,MEMRD,MEMWB. In MEMWB regwrite=1, memtoreg=1, regdst=0; back to FETCH on cycle 6.
- R-type sub (funct=100010) -> RTYPEEX alucontrol=110, alusrcb=00. slt (101010) -> 111; or (100101) -> 001. RTYPEWB regdst=1, regwrite=1.
- beq with zero=1 -> BEQEX pcen=1, pcsrc=01. zero=0 -> pcen=0. bne (SUPPORT_BNE=1) inverts both cases. With SUPPORT_BNE=0, op=000101 -> illegal=1, FETCH next.
- j (op=000010) -> JEX pcsrc=10, pcen=1, 3-cycle instruction. addi -> ADDIEX alusrcb=10, ADDIWB regdst=0, regwrite=1.
- Illegal op=111111, and R-type funct=000111 -> illegal pulses exactly one cycle in DECODE, no write enable asserted, next state FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM: sequences ALU, register file, memory and PC
// for lw, sw, R-type, beq, bne, addi and j, and flags unsupported encodings.
module mc_controller #(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e     state_q, state_d;
    logic       pcwrite, branch, bne;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                if (op == OP_LW || op == OP_SW)                  state_d = MEMADR;
                else if (op == OP_RTYP && funct_ok)              state_d = RTYPEEX;
                else if (op == OP_BEQ || (SUPPORT_BNE && op == OP_BNE)) state_d = BEQEX;
                else if (op == OP_ADDI)                          state_d = ADDIEX;
                else if (op == OP_J)                             state_d = JEX;
                else                                             illegal = 1'b1;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_d    = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                bne        = (op == OP_BNE);
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Write enables must drop immediately while reset is held, whatever the state.
        if (!reset_n) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
        end
        pcen = pcwrite | (branch & (zero ^ bne));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: fixed vector table, reset and SUPPORT_BNE=0
// corner sequences, then random instructions against an instruction-level model.
module tb_mc_controller;

    logic       clk;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero;

    logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    logic pcen0, memwrite0, irwrite0, regwrite0, iord0, memtoreg0, regdst0, alusrca0, illegal0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] alucontrol0;

    mc_controller #(.SUPPORT_BNE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
    );

    mc_controller #(.SUPPORT_BNE(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen0), .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0),
        .iord(iord0), .memtoreg(memtoreg0), .regdst(regdst0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0), .illegal(illegal0)
    );

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        outs_t      third;
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    outs_t exp_q[$];
    vec_t  vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outs_t cur_outs();
        return '{pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                 alusrcb, pcsrc, alucontrol, illegal};
    endfunction

    function automatic outs_t cur_outs0();
        return '{pcen0, memwrite0, irwrite0, regwrite0, iord0, memtoreg0, regdst0, alusrca0,
                 alusrcb0, pcsrc0, alucontrol0, illegal0};
    endfunction

    function automatic outs_t blank();
        outs_t o = '0;
        o.alucontrol = 3'b010;
        return o;
    endfunction

    function automatic outs_t ex(logic pc, logic ir, logic sa, logic [1:0] sb,
                                 logic [1:0] ps, logic [2:0] ac);
        outs_t o = blank();
        o.pcen = pc; o.irwrite = ir; o.alusrca = sa; o.alusrcb = sb;
        o.pcsrc = ps; o.alucontrol = ac;
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the per-cycle output list of one whole instruction, built from its class.
    task automatic build_exp(input logic [5:0] o, input logic [5:0] f, input logic z, input logic sb);
        outs_t s;
        logic [2:0] rf;
        logic rf_ok, is_mem, is_r, is_br, legal;
        rf_ok = 1'b1;
        rf = 3'b010;
        case (f)
            6'b100000: rf = 3'b010;
            6'b100010: rf = 3'b110;
            6'b100100: rf = 3'b000;
            6'b100101: rf = 3'b001;
            6'b101010: rf = 3'b111;
            default:   rf_ok = 1'b0;
        endcase
        is_mem = (o == 6'b100011) || (o == 6'b101011);
        is_r   = (o == 6'b000000) && rf_ok;
        is_br  = (o == 6'b000100) || (sb && o == 6'b000101);
        legal  = is_mem || is_r || is_br || o == 6'b001000 || o == 6'b000010;

        exp_q.delete();
        exp_q.push_back(ex(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 3'b010));
        s = ex(1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b010);
        s.illegal = !legal;
        exp_q.push_back(s);
        if (is_mem) begin
            exp_q.push_back(ex(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010));
            s = blank(); s.iord = 1'b1;
            if (o == 6'b100011) begin
                exp_q.push_back(s);
                s = blank(); s.memtoreg = 1'b1; s.regwrite = 1'b1;
                exp_q.push_back(s);
            end else begin
                s.memwrite = 1'b1;
                exp_q.push_back(s);
            end
        end else if (is_r) begin
            exp_q.push_back(ex(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, rf));
            s = blank(); s.regdst = 1'b1; s.regwrite = 1'b1;
            exp_q.push_back(s);
        end else if (is_br) begin
            exp_q.push_back(ex((o == 6'b000100) ? z : !z, 1'b0, 1'b1, 2'b00, 2'b01, 3'b110));
        end else if (o == 6'b001000) begin
            exp_q.push_back(ex(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010));
            s = blank(); s.regwrite = 1'b1;
            exp_q.push_back(s);
        end else if (o == 6'b000010) begin
            exp_q.push_back(ex(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 3'b010));
        end
    endtask

    // Called with the DUT in FETCH; returns at the FETCH of the following instruction.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
        op = o; funct = f; zero = z;
        build_exp(o, f, z, 1'b1);
        foreach (exp_q[i]) begin
            #1;
            checkOutput($sformatf("model op=%b funct=%b z=%b cyc=%0d", o, f, z, i),
                        32'(cur_outs()), 32'(exp_q[i]));
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        outs_t fetch_v, reset_v, cur, snap;
        int cyc;
        bit done;
        logic [5:0] rops[7];
        logic [5:0] rfns[6];

        fetch_v = ex(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 3'b010);
        reset_v = ex(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010);

        vecs.push_back('{6'b100011, 6'b000000, 1'b0, 5, ex(0, 0, 1, 2'b10, 2'b00, 3'b010)});
        vecs.push_back('{6'b101011, 6'b000000, 1'b0, 4, ex(0, 0, 1, 2'b10, 2'b00, 3'b010)});
        vecs.push_back('{6'b000000, 6'b100000, 1'b0, 4, ex(0, 0, 1, 2'b00, 2'b00, 3'b010)});
        vecs.push_back('{6'b000000, 6'b100010, 1'b0, 4, ex(0, 0, 1, 2'b00, 2'b00, 3'b110)});
        vecs.push_back('{6'b000000, 6'b100100, 1'b0, 4, ex(0, 0, 1, 2'b00, 2'b00, 3'b000)});
        vecs.push_back('{6'b000000, 6'b100101, 1'b0, 4, ex(0, 0, 1, 2'b00, 2'b00, 3'b001)});
        vecs.push_back('{6'b000000, 6'b101010, 1'b0, 4, ex(0, 0, 1, 2'b00, 2'b00, 3'b111)});
        vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, ex(1, 0, 1, 2'b00, 2'b01, 3'b110)});
        vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, ex(0, 0, 1, 2'b00, 2'b01, 3'b110)});
        vecs.push_back('{6'b000101, 6'b000000, 1'b1, 3, ex(0, 0, 1, 2'b00, 2'b01, 3'b110)});
        vecs.push_back('{6'b000101, 6'b000000, 1'b0, 3, ex(1, 0, 1, 2'b00, 2'b01, 3'b110)});
        vecs.push_back('{6'b001000, 6'b000000, 1'b0, 4, ex(0, 0, 1, 2'b10, 2'b00, 3'b010)});
        vecs.push_back('{6'b000010, 6'b000000, 1'b0, 3, ex(1, 0, 0, 2'b00, 2'b10, 3'b010)});
        vecs.push_back('{6'b111111, 6'b000000, 1'b0, 2, ex(1, 1, 0, 2'b01, 2'b00, 3'b010)});
        vecs.push_back('{6'b000000, 6'b000111, 1'b0, 2, ex(1, 1, 0, 2'b01, 2'b00, 3'b010)});

        reset_n = 1'b1; op = '0; funct = '0; zero = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        #1 checkOutput("reset outputs", 32'(cur_outs()), 32'(reset_v));
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("after reset fetch", 32'(cur_outs()), 32'(fetch_v));

        // Table: instruction length and the third-cycle outputs of each class.
        foreach (vecs[k]) begin
            op = vecs[k].op; funct = vecs[k].funct; zero = vecs[k].zero;
            snap = '0; done = 1'b0; cyc = 1;
            @(negedge clk);
            while (!done && cyc < 10) begin
                #1;
                cyc++;
                cur = cur_outs();
                if (cyc == 3) snap = cur;
                if (cur.irwrite) done = 1'b1;
                else @(negedge clk);
            end
            checkOutput($sformatf("vec%0d cycles", k), 32'(cyc - 1), 32'(vecs[k].cycles));
            checkOutput($sformatf("vec%0d third cycle", k), 32'(snap), 32'(vecs[k].third));
            if (!done) pulse_reset();
        end

        // Reset in the middle of sw: memwrite must drop in the same cycle.
        @(negedge clk);
        pulse_reset();
        op = 6'b101011; funct = '0; zero = 1'b0;
        build_exp(6'b101011, 6'b000000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput($sformatf("sw walk cyc=%0d", i), 32'(cur_outs()), 32'(exp_q[i]));
            if (i < 3) @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checkOutput("reset drops memwrite", 32'(memwrite), 32'(1'b0));
        checkOutput("reset mid-sw outputs", 32'(cur_outs()), 32'(reset_v));
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("release fetch", 32'(cur_outs()), 32'(fetch_v));
        applyStimulus(6'b100011, 6'b000000, 1'b0);

        // Random instructions against the instruction-level model.
        rops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
        rfns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] ro, rf;
            ro = ($urandom_range(0, 7) == 7) ? 6'($urandom) : rops[$urandom_range(0, 6)];
            rf = ($urandom_range(0, 5) == 5) ? 6'($urandom) : rfns[$urandom_range(0, 5)];
            applyStimulus(ro, rf, 1'($urandom));
        end

        // SUPPORT_BNE=0 instance: bne is illegal and returns to FETCH.
        pulse_reset();
        op = 6'b000101; funct = '0; zero = 1'b1;
        build_exp(6'b000101, 6'b000000, 1'b1, 1'b0);
        foreach (exp_q[i]) begin
            #1 checkOutput($sformatf("nobne cyc=%0d", i), 32'(cur_outs0()), 32'(exp_q[i]));
            @(negedge clk);
        end
        #1 checkOutput("nobne back to fetch", 32'(cur_outs0()), 32'(fetch_v));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
